led_sequencer: RTL and testbench

- Programmable RGB LED pattern player for the Upduino board LED.
- Replaces the fixed blink counter with a small pattern memory of {colour, duration} steps.
- Played back on a prescaled tick, one-shot or looping.
- Sits between a host/control FSM (writes the pattern, issues start/stop) and the LED driver pins.

---
 rtl/led_sequencer_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 23 ++
 rtl/led_sequencer.sv | 159 +++++++++++++++
 tb/tb_led_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sequencer_pkg.sv
// Shared types and field layout for the LED pattern sequencer.
package led_sequencer_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Pattern entry layout: {rgb[2:0], dur[DBITS-1:0]}, rgb bit2=R, bit1=G, bit0=B.
    localparam int unsigned RgbW = 3;

    function automatic int unsigned entry_w(int unsigned dbits);
        return RgbW + dbits;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler; o_tick is high while the counter is all-ones.
module tick_prescaler #(
    parameter int unsigned CBITS = 21
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    logic [CBITS-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_tick = &cnt_q;

endmodule

// File: rtl/led_sequencer.sv
// Programmable RGB LED pattern player: stores {colour, duration} steps and plays them
// back on a prescaled tick, one-shot or looping.
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int unsigned CBITS = 21,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DBITS = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr_valid,
    output logic                        o_wr_ready,
    input  logic [RgbW+DBITS-1:0]       i_wr_data,
    input  logic                        i_clear,
    input  logic                        i_start,
    input  logic                        i_loop,
    input  logic                        i_stop,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [$clog2(DEPTH)-1:0]    o_step,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_led_r,
    output logic                        o_led_g,
    output logic                        o_led_b
);

    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam int unsigned EntryW = entry_w(DBITS);
    localparam logic [AddrW:0] MaxCount = (AddrW + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [AddrW:0]      count_q, count_d;
    logic [AddrW:0]      len_q, len_d;
    logic [AddrW-1:0]    step_q, step_d;
    logic [DBITS-1:0]    dur_q, dur_d;
    logic [RgbW-1:0]     led_q, led_d;
    logic                loop_q, loop_d;
    logic                done_q, done_d;
    logic [EntryW-1:0]   mem_q [DEPTH];

    logic                wr_fire;
    logic                tick;
    logic [AddrW:0]      eff_count;
    logic [AddrW-1:0]    next_idx;
    logic                last_step;
    logic [RgbW-1:0]     first_rgb;

    tick_prescaler #(
        .CBITS (CBITS)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (state_q == StIdle),
        .o_tick  (tick)
    );

    assign o_wr_ready = (state_q == StIdle) && (count_q < MaxCount) && !i_clear;
    assign wr_fire    = i_wr_valid && o_wr_ready;
    assign eff_count  = count_q + {{AddrW{1'b0}}, wr_fire};
    assign next_idx   = step_q + 1'b1;
    assign last_step  = ({1'b0, step_q} == (len_q - 1'b1));
    // Entry 0 may be arriving in the very cycle playback starts.
    assign first_rgb  = (count_q == '0) ? i_wr_data[EntryW-1:DBITS] : mem_q[0][EntryW-1:DBITS];

    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            mem_q[count_q[AddrW-1:0]] <= i_wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        step_d  = step_q;
        dur_d   = dur_q;
        led_d   = led_q;
        loop_d  = loop_q;
        done_d  = 1'b0;

        if (wr_fire) begin
            count_d = count_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (i_clear) begin
                    count_d = '0;
                end else if (i_start && !i_stop && (eff_count != '0)) begin
                    state_d = StRun;
                    len_d   = eff_count;
                    loop_d  = i_loop;
                    step_d  = '0;
                    dur_d   = '0;
                    led_d   = first_rgb;
                end
            end
            StRun: begin
                if (i_stop) begin
                    state_d = StIdle;
                    step_d  = '0;
                    dur_d   = '0;
                    led_d   = '0;
                end else if (tick) begin
                    if (dur_q == mem_q[step_q][DBITS-1:0]) begin
                        dur_d = '0;
                        if (!last_step) begin
                            step_d = next_idx;
                            led_d  = mem_q[next_idx][EntryW-1:DBITS];
                        end else if (loop_q) begin
                            step_d = '0;
                            led_d  = mem_q[0][EntryW-1:DBITS];
                        end else begin
                            state_d = StIdle;
                            step_d  = '0;
                            led_d   = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        dur_d = dur_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            len_q   <= '0;
            step_q  <= '0;
            dur_q   <= '0;
            led_q   <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            step_q  <= step_d;
            dur_q   <= dur_d;
            led_q   <= led_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

    assign o_busy  = (state_q == StRun);
    assign o_done  = done_q;
    assign o_step  = step_q;
    assign o_count = count_q;
    assign o_led_r = led_q[2];
    assign o_led_g = led_q[1];
    assign o_led_b = led_q[0];

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: per-cycle expected LED/step/busy/done stream
// is built from the written pattern into a scoreboard queue and drained against the DUT.
module tb_led_sequencer;

    localparam int unsigned CBITS   = 2;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned DBITS   = 4;
    localparam int unsigned TickLen = 4;

    typedef struct packed {
        logic [2:0] led;
        logic       busy;
        logic       done;
        logic [2:0] step;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [6:0] wr_data = '0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       loop = 1'b0;
    logic       stop = 1'b0;
    logic       wr_ready, busy, done, led_r, led_g, led_b;
    logic [2:0] step;
    logic [3:0] count;

    obs_t       exp_q[$];
    logic [6:0] pat_q[$];
    int         checks = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    led_sequencer #(
        .CBITS (CBITS),
        .DEPTH (DEPTH),
        .DBITS (DBITS)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .i_wr_data  (wr_data),
        .i_clear    (clear),
        .i_start    (start),
        .i_loop     (loop),
        .i_stop     (stop),
        .o_busy     (busy),
        .o_done     (done),
        .o_step     (step),
        .o_count    (count),
        .o_led_r    (led_r),
        .o_led_g    (led_g),
        .o_led_b    (led_b)
    );

    function automatic obs_t observe();
        return {led_r, led_g, led_b, busy, done, step};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] rgb, input logic [3:0] dur);
        wr_valid = 1'b1;
        wr_data  = {rgb, dur};
        pat_q.push_back({rgb, dur});
        cyc();
        wr_valid = 1'b0;
    endtask

    // Expected stream for one full pass over the pattern.
    task automatic push_pass();
        for (int s = 0; s < pat_q.size(); s++) begin
            logic [6:0] e;
            e = pat_q[s];
            for (int c = 0; c < (int'(e[3:0]) + 1) * int'(TickLen); c++) begin
                exp_q.push_back({e[6:4], 1'b1, 1'b0, 3'(s)});
            end
        end
    endtask

    task automatic push_finish();
        exp_q.push_back({3'b000, 1'b0, 1'b1, 3'b000});
        exp_q.push_back({3'b000, 1'b0, 1'b0, 3'b000});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++;
        if (observe() !== obs_t'(0)) $display("FAIL reset_outputs: got %h expected 00", observe());
        else passed++;
        checks++;
        if (count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", count);
        else passed++;
        checks++;
        if (wr_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", wr_ready);
        else passed++;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_oneshot();
        int n;
        pat_q.delete();
        write_entry(3'b100, 4'd0);
        write_entry(3'b010, 4'd1);
        checks++;
        if (count !== 4'd2) $display("FAIL oneshot_count_pre: got %0d expected 2", count);
        else passed++;
        loop  = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        push_pass();
        push_finish();
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            obs_t e;
            e = exp_q.pop_front();
            checks++;
            if (observe() !== e) $display("FAIL oneshot_cyc%0d: got %h expected %h", i, observe(), e);
            else passed++;
            cyc();
        end
        checks++;
        if (count !== 4'd2) $display("FAIL oneshot_count_post: got %0d expected 2", count);
        else passed++;
    endtask

    task automatic test_loop_stop();
        int n;
        loop  = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        loop  = 1'b0;
        for (int r = 0; r < 4; r++) push_pass();
        while (exp_q.size() > 42) void'(exp_q.pop_back());
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            obs_t e;
            e = exp_q.pop_front();
            checks++;
            if (observe() !== e) $display("FAIL loop_cyc%0d: got %h expected %h", i, observe(), e);
            else passed++;
            cyc();
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if (observe() !== obs_t'(0)) $display("FAIL loop_stop_idle: got %h expected 00", observe());
        else passed++;
        cyc();
        checks++;
        if ({busy, done} !== 2'b00) $display("FAIL loop_stop_nodone: got %b expected 00", {busy, done});
        else passed++;
        checks++;
        if (count !== 4'd2) $display("FAIL loop_stop_count: got %0d expected 2", count);
        else passed++;
    endtask

    task automatic test_full();
        int n;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        pat_q.delete();
        checks++;
        if (count !== 4'd0) $display("FAIL full_clear_count: got %0d expected 0", count);
        else passed++;
        for (int i = 0; i < 8; i++) write_entry(3'((i % 7) + 1), 4'(i % 2));
        checks++;
        if (wr_ready !== 1'b0) $display("FAIL full_ready_low: got %b expected 0", wr_ready);
        else passed++;
        wr_valid = 1'b1;
        wr_data  = 7'h7f;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_ready !== 1'b0) $display("FAIL full_hold%0d: got %b expected 0", i, wr_ready);
            else passed++;
            cyc();
        end
        wr_valid = 1'b0;
        checks++;
        if (count !== 4'd8) $display("FAIL full_count: got %0d expected 8", count);
        else passed++;
        loop  = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        loop  = 1'b0;
        push_pass();
        push_pass();
        while (exp_q.size() > 52) void'(exp_q.pop_back());
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            obs_t e;
            e = exp_q.pop_front();
            checks++;
            if (observe() !== e) $display("FAIL full_cyc%0d: got %h expected %h", i, observe(), e);
            else passed++;
            cyc();
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if (observe() !== obs_t'(0)) $display("FAIL full_stop: got %h expected 00", observe());
        else passed++;
    endtask

    task automatic test_clear();
        wr_valid = 1'b1;
        wr_data  = {3'b111, 4'd3};
        clear    = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b0) $display("FAIL clear_ready: got %b expected 0", wr_ready);
        else passed++;
        cyc();
        wr_valid = 1'b0;
        clear    = 1'b0;
        checks++;
        if (count !== 4'd0) $display("FAIL clear_count: got %0d expected 0", count);
        else passed++;
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (observe() !== obs_t'(0)) $display("FAIL clear_start_empty: got %h expected 00", observe());
        else passed++;
        cyc();
        checks++;
        if (busy !== 1'b0) $display("FAIL clear_start_busy: got %b expected 0", busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        pat_q.delete();
        write_entry(3'b001, 4'd0);
        wr_valid = 1'b1;
        wr_data  = {3'b110, 4'd1};
        pat_q.push_back({3'b110, 4'd1});
        loop  = 1'b0;
        start = 1'b1;
        cyc();
        wr_valid = 1'b0;
        start    = 1'b0;
        checks++;
        if (count !== 4'd2) $display("FAIL b2b_count: got %0d expected 2", count);
        else passed++;
        push_pass();
        push_finish();
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            obs_t e;
            e = exp_q.pop_front();
            checks++;
            if (observe() !== e) $display("FAIL b2b_cyc%0d: got %h expected %h", i, observe(), e);
            else passed++;
            cyc();
        end
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (observe() !== obs_t'(0)) $display("FAIL b2b_start_stop: got %h expected 00", observe());
        else passed++;
        cyc();
        checks++;
        if (busy !== 1'b0) $display("FAIL b2b_start_stop_busy: got %b expected 0", busy);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int n;
        loop  = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        loop  = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        checks++;
        if (busy !== 1'b1) $display("FAIL rstrun_busy: got %b expected 1", busy);
        else passed++;
        rst_n = 1'b0;
        cyc();
        checks++;
        if (observe() !== obs_t'(0)) $display("FAIL rstrun_outputs: got %h expected 00", observe());
        else passed++;
        checks++;
        if (count !== 4'd0) $display("FAIL rstrun_count: got %0d expected 0", count);
        else passed++;
        rst_n = 1'b1;
        pat_q.delete();
        write_entry(3'b101, 4'd2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        push_pass();
        push_finish();
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            obs_t e;
            e = exp_q.pop_front();
            checks++;
            if (observe() !== e) $display("FAIL rstrun_cyc%0d: got %h expected %h", i, observe(), e);
            else passed++;
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_loop_stop();
        test_full();
        test_clear();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
